// File: rtl/count_sequencer.sv
// Round-robin sequencer that drives a shared up/down counter to a requested target value.
// Optional build macro COUNT_SEQ_TIMEOUT_EN adds a RUN-cycle timer that aborts with err.
module count_sequencer #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_target0,
    input  logic [WIDTH-1:0] req_target1,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] count,
    output logic             UpOrDown,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] target_q;
    logic             id_q;
    logic             last_grant;
    logic             up_q;
    logic             grant_valid;
    logic             grant_id;
    logic             at_target;
    logic             go_up;
    logic             timed_out;

    // Arbitration and distance compare
    always_comb begin
        grant_valid = |req_valid;
        grant_id    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        at_target   = (count == target_q);
        go_up       = (target_q > count);
    end

`ifdef COUNT_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);

    logic [TW-1:0] timer_q;
    logic          err_q;

    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ST_IDLE && grant_valid) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ST_RUN && !at_target) begin
            if (timed_out) begin
                err_q <= 1'b1;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_valid) state_nxt = ST_RUN;
            ST_RUN:  if (at_target || timed_out) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; direction holds its last commanded value outside stepping cycles
    always_comb begin
        req_ready = 2'b00;
        UpOrDown  = up_q;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        done_id   = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) req_ready = grant_id ? 2'b10 : 2'b01;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!at_target && !timed_out) begin
                    cnt_en   = 1'b1;
                    UpOrDown = go_up;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                done_id = id_q;
`ifdef COUNT_SEQ_TIMEOUT_EN
                err     = err_q;
`endif
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Command latch, round-robin history and held direction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q   <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            up_q       <= 1'b0;
        end else begin
            if (state == ST_IDLE && grant_valid) begin
                target_q   <= grant_id ? req_target1 : req_target0;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (cnt_en) up_q <= go_up;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural up/down counter attached.
module tb_count_sequencer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_target0;
    logic [WIDTH-1:0] req_target1;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] count;
    logic             UpOrDown;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             err;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             stuck;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_target0(req_target0), .req_target1(req_target1),
        .req_ready(req_ready), .count(count), .UpOrDown(UpOrDown),
        .cnt_en(cnt_en), .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter model: loadable, can be frozen to emulate a stuck counter
    always @(posedge clk) begin
        if (load) count <= load_val;
        else if (cnt_en && !stuck) count <= UpOrDown ? count + 4'd1 : count - 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_count(input logic [WIDTH-1:0] v);
        load_val = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
        #1 check("load_count", 32'(count), 32'(v));
    endtask

    // One command from accept to the idle cycle after done
    task automatic run_cmd(input logic id, input logic [WIDTH-1:0] tgt, input int d, input logic up);
        if (id) req_target1 = tgt; else req_target0 = tgt;
        req_valid = id ? 2'b10 : 2'b01;
        #1 check("accept_ready", 32'(req_ready), id ? 32'h2 : 32'h1);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < d; i++) begin
            #1 check("run_step", {29'd0, busy, cnt_en, UpOrDown}, {29'd0, 1'b1, 1'b1, up});
            step();
        end
        #1 check("no_overshoot", {29'd0, busy, cnt_en, done}, 32'h4);
        check("arrived", 32'(count), 32'(tgt));
        step();
        #1 check("done_pulse", {28'd0, done, done_id, err, cnt_en}, {28'd0, 1'b1, id, 1'b0, 1'b0});
        step();
        #1 check("back_idle", {30'd0, busy, done}, 32'h0);
        if (d > 0) check("dir_held", 32'(UpOrDown), 32'(up));
    endtask

    int grant_ids[4];
    int grant_cyc[4];
    int ngrant;
    int en_cycles;
    bit seen_done;
    bit seen_err;

    initial begin
        reset       = 1'b0;
        req_valid   = 2'b00;
        req_target0 = '0;
        req_target1 = '0;
        load        = 1'b0;
        load_val    = '0;
        stuck       = 1'b0;
        count       = '0;
        step();
        step();
        reset = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 10; i++) begin
            #1 check("reset_idle", {24'd0, req_ready, UpOrDown, cnt_en, busy, done, done_id, err}, 32'h0);
            step();
        end

        load_count(4'd0);
        run_cmd(1'b0, 4'd5, 5, 1'b1);
        run_cmd(1'b1, 4'd2, 3, 1'b0);
        load_count(4'd7);
        run_cmd(1'b0, 4'd7, 0, 1'b0);

        // Reset during RUN drops the command
        req_target0 = 4'd15;
        req_valid   = 2'b01;
        #1 check("rst_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        step();
        #1 check("rst_pre_en", 32'(cnt_en), 32'h1);
        reset = 1'b0;
        #1 check("rst_async", {28'd0, cnt_en, busy, done, UpOrDown}, 32'h0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("rst_dropped", {30'd0, busy, done}, 32'h0);
            step();
        end

        // Both held valid: grants alternate starting with requester 0
        load_count(4'd0);
        req_target0 = 4'd2;
        req_target1 = 4'd0;
        req_valid   = 2'b11;
        ngrant      = 0;
        for (int c = 0; c < 60 && ngrant < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                grant_ids[ngrant] = (req_ready == 2'b10) ? 1 : 0;
                grant_cyc[ngrant] = c;
                ngrant++;
            end
            step();
        end
        req_valid = 2'b00;
        check("rr_grant_count", 32'(ngrant), 32'd4);
        for (int g = 0; g < 4; g++) begin
            check("rr_grant_id", 32'(grant_ids[g]), 32'(g % 2));
            if (g > 0) check("rr_gap", 32'(grant_cyc[g] - grant_cyc[g-1]), 32'd5);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            #1 if (done) seen_done = 1'b1;
            step();
        end
        check("rr_drain", 32'(seen_done), 32'h1);
        check("rr_final_count", 32'(count), 32'd0);

        // Stuck counter
        load_count(4'd0);
        stuck       = 1'b1;
        req_target0 = 4'd9;
        req_valid   = 2'b01;
        #1 check("stuck_accept", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        en_cycles = 0;
        seen_done = 1'b0;
        seen_err  = 1'b0;
`ifdef COUNT_SEQ_TIMEOUT_EN
        for (int c = 0; c < 80 && !seen_done; c++) begin
            #1;
            if (done) begin
                seen_done = 1'b1;
                seen_err  = err;
            end else if (cnt_en) en_cycles++;
            step();
        end
        check("to_en_cycles", 32'(en_cycles), 32'd32);
        check("to_done", 32'(seen_done), 32'h1);
        check("to_err", 32'(seen_err), 32'h1);
        check("to_count", 32'(count), 32'd0);
        stuck = 1'b0;
`else
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) seen_done = 1'b1;
            if (cnt_en) en_cycles++;
            step();
        end
        check("stuck_no_done", 32'(seen_done), 32'h0);
        check("stuck_en_cycles", 32'(en_cycles), 32'd40);
        stuck = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            #1;
            if (done) begin
                seen_done = 1'b1;
                seen_err  = err;
            end
            step();
        end
        check("release_done", 32'(seen_done), 32'h1);
        check("release_err", 32'(seen_err), 32'h0);
        check("release_count", 32'(count), 32'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
